// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared state encoding and default sizes for shift_chain_ctrl
package shift_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/shift_chain_ctrl.sv
// rtl/shift_chain_ctrl.sv - streams a word MSB-first through a DEPTH-stage serial chain and
// recaptures it from the chain tail after DEPTH flush zeros
module shift_chain_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  output logic             ser_out,
  output logic             ser_en,
  input  logic             ser_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CW   = $clog2(WIDTH + DEPTH + 1);
  localparam int LAST = WIDTH + DEPTH - 1;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_word;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_shift_nxt;
  logic             shifting;
  logic             tx_bit;
  logic             capture;
  logic             last_shift;

  always_comb begin
    shifting   = (state == ST_SHIFT) && !stall;
    capture    = shifting && (int'(cnt) >= DEPTH) && (int'(cnt) <= LAST);
    last_shift = shifting && (int'(cnt) == LAST);

    // Only counts below WIDTH match a bit position, so the flush phase falls out as zero.
    tx_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(cnt) == WIDTH - 1 - i) tx_bit = tx_word[i];
    end

    rx_shift_nxt[0] = ser_in;
    for (int i = 1; i < WIDTH; i++) begin
      rx_shift_nxt[i] = rx_shift[i-1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_SHIFT) || (state == ST_DONE);
    done     = (state == ST_DONE);
    ser_en   = shifting;
    ser_out  = shifting && tx_bit;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tx_word  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && in_valid) begin
        tx_word  <= in_data;
        cnt      <= '0;
        rx_shift <= '0;
      end
      if (shifting) cnt <= cnt + CW'(1);
      if (capture) rx_shift <= rx_shift_nxt;
      // Publish including the final tail bit so rx_data is already valid while done is high.
      if (last_shift) rx_data <= rx_shift_nxt;
    end
  end

endmodule
